axi_stream_extract_header: RTL and testbench

//  Receive-side counterpart of the header-insert stage: strips a byte_extract_cnt-byte header from the

---
 rtl/axis_hdr_pkg.sv | 28 ++
 rtl/axis_hdr_realign.sv | 55 +++++
 rtl/axi_stream_extract_header.sv | 145 ++++++++++++++
 tb/tb_axi_stream_extract_header.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_hdr_pkg.sv
// rtl/axis_hdr_pkg.sv - shared types and keep/count helpers for the header-extract stage
package axis_hdr_pkg;

    typedef enum logic [1:0] {HDR, STREAM, FLUSH} state_t;

    localparam int MAX_BYTES = 64;
    typedef logic [MAX_BYTES-1:0] kb_t;

    function automatic int keep_to_cnt(input kb_t keep);
        int c;
        c = 0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (keep[i]) c++;
        end
        return c;
    endfunction

    // MSB-aligned: the top cnt lanes of a lanes-wide keep are set
    function automatic kb_t cnt_to_keep(input int cnt, input int lanes);
        kb_t k;
        k = '0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (i < lanes && i >= lanes - cnt) k[i] = 1'b1;
        end
        return k;
    endfunction

endpackage

// File: rtl/axis_hdr_realign.sv
// rtl/axis_hdr_realign.sv - combinational merge of carried residual bytes with the incoming beat
module axis_hdr_realign
    import axis_hdr_pkg::*;
#(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD + 1)
) (
    input  logic [DATA_WD-1:0]      i_res,
    input  logic [DATA_WD-1:0]      i_data,
    input  logic [DATA_BYTE_WD-1:0] i_keep,
    input  logic [BYTE_CNT_WD-1:0]  i_h,
    output logic [DATA_WD-1:0]      o_data,
    output logic [DATA_BYTE_WD-1:0] o_keep,
    output logic [DATA_WD-1:0]      o_res,
    output logic [DATA_BYTE_WD-1:0] o_rem_keep,
    output logic                    o_ovf,
    output logic [DATA_WD-1:0]      o_hdr_data,
    output logic [DATA_BYTE_WD-1:0] o_hdr_keep
);
    logic [DATA_WD-1:0]      w_beat;
    logic [DATA_WD-1:0]      w_hmask;
    logic [DATA_BYTE_WD-1:0] w_hkeep;
    int                      w_n;
    int                      w_h;
    int                      w_r;

    always_comb begin
        w_beat  = '0;
        w_hmask = '0;
        w_n     = keep_to_cnt(kb_t'(i_keep));
        w_h     = int'(i_h);
        w_r     = DATA_BYTE_WD - w_h;
        w_hkeep = DATA_BYTE_WD'(cnt_to_keep(w_h, DATA_BYTE_WD));
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            w_beat[8*i +: 8]  = i_data[8*i +: 8] & {8{i_keep[i]}};
            w_hmask[8*i +: 8] = {8{w_hkeep[i]}};
        end
        o_hdr_data = w_beat & w_hmask;
        o_hdr_keep = DATA_BYTE_WD'(cnt_to_keep((w_n < w_h) ? w_n : w_h, DATA_BYTE_WD));
        o_res      = w_beat << (8 * w_h);
        o_rem_keep = DATA_BYTE_WD'(cnt_to_keep((w_n > w_h) ? w_n - w_h : 0, DATA_BYTE_WD));
        // With no header the residual would be a whole beat; pass the beat straight through instead
        if (w_h == 0) begin
            o_data = w_beat;
            o_keep = i_keep;
            o_ovf  = 1'b0;
        end else begin
            o_data = i_res | (w_beat >> (8 * w_r));
            o_keep = DATA_BYTE_WD'(cnt_to_keep((w_n > w_h) ? DATA_BYTE_WD : w_r + w_n, DATA_BYTE_WD));
            o_ovf  = (w_n > w_h);
        end
    end

endmodule

// File: rtl/axi_stream_extract_header.sv
// rtl/axi_stream_extract_header.sv - strips a leading header from each packet; optional HDR_SHORT_ERR_EN adds err_short
module axi_stream_extract_header
    import axis_hdr_pkg::*;
#(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_in,
    output logic                    ready_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    input  logic [BYTE_CNT_WD-1:0]  byte_extract_cnt,
    output logic                    valid_out,
    input  logic                    ready_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    output logic                    valid_header,
    input  logic                    ready_header,
    output logic [DATA_WD-1:0]      data_header,
    output logic [DATA_BYTE_WD-1:0] keep_header
`ifdef HDR_SHORT_ERR_EN
    ,
    output logic                    err_short
`endif
);
    state_t                  r_state;
    logic [BYTE_CNT_WD-1:0]  r_h;
    logic [BYTE_CNT_WD-1:0]  w_h;
    logic [DATA_WD-1:0]      r_res, r_data_out, r_data_header;
    logic [DATA_BYTE_WD-1:0] r_flush_keep, r_keep_out, r_keep_header;
    logic                    r_valid_out, r_last_out, r_valid_header;
    logic                    w_out_free, w_hdr_free, w_acc, w_ovf;
    logic [DATA_WD-1:0]      w_data, w_res, w_hdr_data;
    logic [DATA_BYTE_WD-1:0] w_keep, w_rem_keep, w_hdr_keep;

    // Header length is live only on the first beat; afterwards the captured copy rules
    always_comb begin
        w_h = r_h;
        if (r_state == HDR) begin
            w_h = (byte_extract_cnt > BYTE_CNT_WD'(DATA_BYTE_WD)) ? BYTE_CNT_WD'(DATA_BYTE_WD)
                                                                  : byte_extract_cnt;
        end
    end

    assign w_out_free = !r_valid_out || ready_out;
    assign w_hdr_free = !r_valid_header || ready_header;
    assign ready_in   = (r_state != FLUSH) && w_out_free && (r_state != HDR || w_hdr_free);
    assign w_acc      = valid_in && ready_in;

    axis_hdr_realign #(
        .DATA_WD      (DATA_WD),
        .DATA_BYTE_WD (DATA_BYTE_WD),
        .BYTE_CNT_WD  (BYTE_CNT_WD)
    ) u_realign (
        .i_res      (r_res),
        .i_data     (data_in),
        .i_keep     (keep_in),
        .i_h        (w_h),
        .o_data     (w_data),
        .o_keep     (w_keep),
        .o_res      (w_res),
        .o_rem_keep (w_rem_keep),
        .o_ovf      (w_ovf),
        .o_hdr_data (w_hdr_data),
        .o_hdr_keep (w_hdr_keep)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= HDR;
            r_h            <= '0;
            r_res          <= '0;
            r_flush_keep   <= '0;
            r_valid_out    <= 1'b0;
            r_data_out     <= '0;
            r_keep_out     <= '0;
            r_last_out     <= 1'b0;
            r_valid_header <= 1'b0;
            r_data_header  <= '0;
            r_keep_header  <= '0;
        end else begin
            if (ready_out)    r_valid_out    <= 1'b0;
            if (ready_header) r_valid_header <= 1'b0;
            case (r_state)
                HDR: if (w_acc) begin
                    r_h   <= w_h;
                    r_res <= w_res;
                    if (w_h != '0) begin
                        r_valid_header <= 1'b1;
                        r_data_header  <= w_hdr_data;
                        r_keep_header  <= w_hdr_keep;
                    end
                    if (w_h == '0 || (last_in && w_ovf)) begin
                        r_valid_out <= 1'b1;
                        r_data_out  <= w_res;
                        r_keep_out  <= w_rem_keep;
                        r_last_out  <= last_in;
                    end
                    r_state <= last_in ? HDR : STREAM;
                end
                STREAM: if (w_acc) begin
                    r_res        <= w_res;
                    r_flush_keep <= w_rem_keep;
                    r_valid_out  <= 1'b1;
                    r_data_out   <= w_data;
                    r_keep_out   <= w_keep;
                    r_last_out   <= last_in && !w_ovf;
                    if (last_in) r_state <= w_ovf ? FLUSH : HDR;
                end
                FLUSH: if (w_out_free) begin
                    r_valid_out <= 1'b1;
                    r_data_out  <= r_res;
                    r_keep_out  <= r_flush_keep;
                    r_last_out  <= 1'b1;
                    r_state     <= HDR;
                end
                default: r_state <= HDR;
            endcase
        end
    end

    assign valid_out    = r_valid_out;
    assign data_out     = r_data_out;
    assign keep_out     = r_keep_out;
    assign last_out     = r_last_out;
    assign valid_header = r_valid_header;
    assign data_header  = r_data_header;
    assign keep_header  = r_keep_header;

`ifdef HDR_SHORT_ERR_EN
    logic r_err_short;
    always_ff @(posedge clk) begin
        if (rst) r_err_short <= 1'b0;
        else     r_err_short <= w_acc && (r_state == HDR) && last_in
                                && (keep_to_cnt(kb_t'(keep_in)) < int'(w_h));
    end
    assign err_short = r_err_short;
`endif

endmodule

// File: tb/tb_axi_stream_extract_header.sv
// tb/tb_axi_stream_extract_header.sv - scoreboard bench for axi_stream_extract_header
module tb_axi_stream_extract_header;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in, ready_in, last_in;
    logic [31:0] data_in;
    logic [3:0]  keep_in;
    logic [2:0]  byte_extract_cnt;
    logic        valid_out, ready_out, last_out;
    logic [31:0] data_out;
    logic [3:0]  keep_out;
    logic        valid_header, ready_header;
    logic [31:0] data_header;
    logic [3:0]  keep_header;
    logic        err_short;

    always #5 clk = ~clk;

    axi_stream_extract_header dut (
        .clk              (clk),
        .rst              (rst),
        .valid_in         (valid_in),
        .ready_in         (ready_in),
        .data_in          (data_in),
        .keep_in          (keep_in),
        .last_in          (last_in),
        .byte_extract_cnt (byte_extract_cnt),
        .valid_out        (valid_out),
        .ready_out        (ready_out),
        .data_out         (data_out),
        .keep_out         (keep_out),
        .last_out         (last_out),
        .valid_header     (valid_header),
        .ready_header     (ready_header),
        .data_header      (data_header),
        .keep_header      (keep_header)
`ifdef HDR_SHORT_ERR_EN
        ,
        .err_short        (err_short)
`endif
    );

`ifndef HDR_SHORT_ERR_EN
    assign err_short = 1'b0;
`endif

    typedef struct packed { logic [31:0] d; logic [3:0] k; logic l; } pb_t;
    typedef struct packed { logic [31:0] d; logic [3:0] k; } hb_t;

    pb_t exp_pay[$];
    hb_t exp_hdr[$];
    int  total = 0;
    int  bad = 0;
    int  err_seen = 0;
    int  err_exp = 0;
    logic bp_done = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    initial begin : monitor
        pb_t  e;
        hb_t  eh;
        pb_t  held;
        logic stall_prev;
        stall_prev = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev)
                    check("stall hold", 64'({valid_out, data_out, keep_out, last_out}), 64'({1'b1, held}));
                stall_prev = valid_out && !ready_out;
                held = {data_out, keep_out, last_out};
                if (valid_out && ready_out) begin
                    if (exp_pay.size() == 0) begin
                        check("unexpected payload", 64'({data_out, keep_out, last_out}), 64'(0));
                    end else begin
                        e = exp_pay.pop_front();
                        check("payload", 64'({data_out, keep_out, last_out}), 64'(e));
                    end
                end
                if (valid_header && ready_header) begin
                    if (exp_hdr.size() == 0) begin
                        check("unexpected header", 64'({data_header, keep_header}), 64'(0));
                    end else begin
                        eh = exp_hdr.pop_front();
                        check("header", 64'({data_header, keep_header}), 64'(eh));
                    end
                end
                if (err_short) err_seen++;
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l, input logic [2:0] h);
        int n;
        valid_in = 1'b1; data_in = d; keep_in = k; last_in = l; byte_extract_cnt = h;
        n = 0;
        @(negedge clk);
        while (!ready_in && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ready_in) check("accept timeout", 64'(ready_in), 64'(1));
        @(posedge clk);
        #1;
        valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
    endtask

    task automatic pkt1();
        exp_hdr.push_back({32'hAABB0000, 4'b1100});
        exp_pay.push_back({32'hCCDD1122, 4'b1111, 1'b0});
        exp_pay.push_back({32'h33445566, 4'b1111, 1'b0});
        exp_pay.push_back({32'h77880000, 4'b1100, 1'b1});
        send(32'hAABBCCDD, 4'b1111, 1'b0, 3'd2);
        send(32'h11223344, 4'b1111, 1'b0, 3'd1);
        send(32'h55667788, 4'b1111, 1'b1, 3'd1);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_pay.size() != 0 || exp_hdr.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check({name, " payload left"}, 64'(exp_pay.size()), 64'(0));
        check({name, " header left"}, 64'(exp_hdr.size()), 64'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
        byte_extract_cnt = '0; ready_out = 1'b1; ready_header = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset valid_out", 64'(valid_out), 64'(0));
        check("reset valid_header", 64'(valid_header), 64'(0));
        check("reset out regs", 64'({data_out, keep_out, last_out}), 64'(0));
        check("reset hdr regs", 64'({data_header, keep_header}), 64'(0));
        check("reset ready_in", 64'(ready_in), 64'(1));
        check("reset err_short", 64'(err_short), 64'(0));
        @(posedge clk);
        #1;

        pkt1();
        drain("h2");

        exp_hdr.push_back({32'hDEADBEEF, 4'b1111});
        send(32'hDEADBEEF, 4'b1111, 1'b1, 3'd4);
        drain("h4");
        check("h4 back in HDR", 64'(ready_in), 64'(1));

        exp_hdr.push_back({32'hA1B20000, 4'b1100});
        err_exp++;
        send(32'hA1B20000, 4'b1100, 1'b1, 3'd3);
        drain("h3 short");

        exp_pay.push_back({32'h01020304, 4'b1111, 1'b0});
        exp_pay.push_back({32'h05060000, 4'b1100, 1'b1});
        send(32'h01020304, 4'b1111, 1'b0, 3'd0);
        send(32'h05060000, 4'b1100, 1'b1, 3'd1);
        drain("h0");

        ready_header = 1'b0;
        exp_hdr.push_back({32'hDEADBEEF, 4'b1111});
        send(32'hDEADBEEF, 4'b1111, 1'b1, 3'd4);
        fork
            begin
                while (!bp_done) begin
                    @(posedge clk);
                    #1 ready_out = ~ready_out;
                end
            end
        join_none
        fork
            pkt1();
            begin
                repeat (5) begin
                    @(negedge clk);
                    check("bp ready_in", 64'(ready_in), 64'(0));
                    check("bp header hold", 64'({valid_header, data_header, keep_header}),
                          64'({1'b1, 32'hDEADBEEF, 4'b1111}));
                end
                @(posedge clk);
                #1 ready_header = 1'b1;
            end
        join
        bp_done = 1'b1;
        drain("backpressure");
        @(posedge clk);
        #2 ready_out = 1'b1;

        exp_hdr.push_back({32'hAABB0000, 4'b1100});
        exp_pay.push_back({32'hCCDD1122, 4'b1111, 1'b0});
        send(32'hAABBCCDD, 4'b1111, 1'b0, 3'd2);
        send(32'h11223344, 4'b1111, 1'b0, 3'd2);
        send(32'h55667788, 4'b1111, 1'b1, 3'd2);
        ready_out = 1'b0;
        @(negedge clk);
        check("flush ready_in", 64'(ready_in), 64'(0));
        check("flush held beat", 64'({valid_out, data_out, keep_out, last_out}),
              64'({1'b1, 32'h33445566, 4'b1111, 1'b0}));
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post-rst valid_out", 64'(valid_out), 64'(0));
        check("post-rst valid_header", 64'(valid_header), 64'(0));
        check("post-rst ready_in", 64'(ready_in), 64'(1));
        @(posedge clk);
        #1 ready_out = 1'b1;
        check("post-rst queues", 64'({exp_pay.size(), exp_hdr.size()}), 64'(0));
        pkt1();
        drain("after reset");

`ifdef HDR_SHORT_ERR_EN
        check("err_short pulses", 64'(err_seen), 64'(err_exp));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
